// File: rtl/keypad_entry_decoder_pkg.sv
// Shared types and constants for the keypad entry decoder and its digit cells.
// Indices are typed 2-bit so they compare cleanly against arbitration results.
package keypad_entry_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [1:0] CMD_ADD      = 2'd0;
  localparam logic [1:0] CMD_REMOVE   = 2'd1;
  localparam logic [1:0] CMD_CHECKOUT = 2'd2;
  localparam logic [1:0] CMD_CANCEL   = 2'd3;

  localparam logic [1:0] KEY_INC  = 2'd0;
  localparam logic [1:0] KEY_DEC  = 2'd1;
  localparam logic [1:0] KEY_NEXT = 2'd2;
  localparam logic [1:0] KEY_CLR  = 2'd3;

  // Lowest set bit wins; result is meaningless when v == 0.
  function automatic logic [1:0] lowest_idx(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

endpackage

// File: rtl/keypad_entry_decoder_digit_cell.sv
// One BCD digit register with increment/decrement wrapping inside 0..9.
// Clear has priority over increment and decrement.
module bcd_digit_cell (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       clr_i,
  output logic [3:0] digit_o
);

  logic [3:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr_i)      digit_d = 4'd0;
    else if (inc_i) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
    else if (dec_i) digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) digit_q <= 4'd0;
    else         digit_q <= digit_d;
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/keypad_entry_decoder.sv
// Turns key/command pulses into a BCD entry with cursor and issues sale
// commands. Handshake: CMD_VALID holds code/entry stable until CMD_READY.
module keypad_entry_decoder
  import keypad_entry_decoder_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int TIMEOUT_W      = 26
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic [3:0]              KEY_En,
  input  logic [3:0]              CMD_En,
  input  logic                    CMD_READY,
  output logic                    CMD_VALID,
  output logic [1:0]              CMD_CODE,
  output logic [4*NUM_DIGITS-1:0] CMD_ENTRY,
  output logic [4*NUM_DIGITS-1:0] ENTRY_BCD,
  output logic [2:0]              CURSOR,
  output logic                    EDITING,
  output logic                    ERR,
  output logic                    TIMEOUT
);

  state_t                  state_q;
  logic [2:0]              cursor_q, cursor_d;
  logic [TIMEOUT_W-1:0]    cnt_q, cnt_d;
  logic                    valid_q, err_q, timeout_q;
  logic [1:0]              code_q;
  logic [4*NUM_DIGITS-1:0] centry_q;

  logic       cmd_any, key_any, key_ok, idle_tick, timeout_hit, handshake;
  logic [1:0] cmd_idx, key_idx;
  logic       dig_inc, dig_dec, dig_clr;

  // Commands beat keys; keys are only consumed outside HOLD.
  always_comb begin
    cmd_any     = |CMD_En;
    key_any     = |KEY_En;
    cmd_idx     = lowest_idx(CMD_En);
    key_idx     = lowest_idx(KEY_En);
    key_ok      = key_any && !cmd_any && (state_q != HOLD);
    idle_tick   = (state_q == EDIT) && !cmd_any && !key_any;
    timeout_hit = idle_tick && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 2));
    handshake   = valid_q && CMD_READY;
    dig_inc     = key_ok && (key_idx == KEY_INC);
    dig_dec     = key_ok && (key_idx == KEY_DEC);
    dig_clr     = (key_ok && (key_idx == KEY_CLR))
               || ((state_q == EDIT) && cmd_any && (cmd_idx == CMD_CANCEL))
               || timeout_hit || handshake;

    cursor_d = cursor_q;
    if (dig_clr)
      cursor_d = 3'd0;
    else if (key_ok && (key_idx == KEY_NEXT))
      cursor_d = (cursor_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : cursor_q + 3'd1;

    cnt_d = '0;
    if (idle_tick && !timeout_hit) cnt_d = cnt_q + 1'b1;
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic sel;
    assign sel = (cursor_q == 3'(i));
    bcd_digit_cell u_cell (
      .clk_i   (CLOCK_50),
      .rst_ni  (RESET_N),
      .inc_i   (dig_inc && sel),
      .dec_i   (dig_dec && sel),
      .clr_i   (dig_clr),
      .digit_o (ENTRY_BCD[4*i +: 4])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      cursor_q  <= 3'd0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      code_q    <= 2'd0;
      centry_q  <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cursor_q  <= cursor_d;
      cnt_q     <= cnt_d;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_any) begin
            if (cmd_idx == CMD_CHECKOUT) begin
              state_q  <= HOLD;
              valid_q  <= 1'b1;
              code_q   <= CMD_CHECKOUT;
              centry_q <= '0;
            end else if (cmd_idx != CMD_CANCEL) begin
              err_q <= 1'b1;
            end
          end else if (key_any) begin
            state_q <= EDIT;
          end
        end
        EDIT: begin
          if (cmd_any) begin
            if (cmd_idx == CMD_CANCEL) begin
              state_q <= IDLE;
            end else begin
              state_q  <= HOLD;
              valid_q  <= 1'b1;
              code_q   <= cmd_idx;
              centry_q <= ENTRY_BCD;
            end
          end else if (timeout_hit) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end
        end
        HOLD: begin
          if (cmd_any || key_any) err_q <= 1'b1;
          if (CMD_READY) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign CMD_VALID = valid_q;
  assign CMD_CODE  = code_q;
  assign CMD_ENTRY = centry_q;
  assign CURSOR    = cursor_q;
  assign EDITING   = (state_q == EDIT);
  assign ERR       = err_q;
  assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_keypad_entry_decoder.sv
// Bench for keypad_entry_decoder: vector table, timeout and async-reset
// sequences, and random pulses checked against a rule-level model.
module tb_keypad_entry_decoder;

  localparam int N  = 3;
  localparam int TO = 16;
  localparam int W  = 4 * N;

  logic         CLOCK_50 = 1'b0;
  logic         RESET_N  = 1'b0;
  logic [3:0]   KEY_En, CMD_En;
  logic         CMD_READY;
  logic         CMD_VALID, EDITING, ERR, TIMEOUT;
  logic [1:0]   CMD_CODE;
  logic [W-1:0] CMD_ENTRY, ENTRY_BCD;
  logic [2:0]   CURSOR;

  keypad_entry_decoder #(.NUM_DIGITS(N), .TIMEOUT_CYCLES(TO), .TIMEOUT_W(26)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .KEY_En    (KEY_En),
    .CMD_En    (CMD_En),
    .CMD_READY (CMD_READY),
    .CMD_VALID (CMD_VALID),
    .CMD_CODE  (CMD_CODE),
    .CMD_ENTRY (CMD_ENTRY),
    .ENTRY_BCD (ENTRY_BCD),
    .CURSOR    (CURSOR),
    .EDITING   (EDITING),
    .ERR       (ERR),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = idle, 1 = editing, 2 = waiting for handshake.
  int           m_mode, m_cur, m_idle;
  int           m_dig[N];
  logic         m_valid, m_err, m_to;
  logic [1:0]   m_code;
  logic [W-1:0] m_centry;
  logic [W+1:0] exp_q[$];

  function automatic logic [W-1:0] m_pack();
    logic [W-1:0] e;
    for (int i = 0; i < N; i++) e[4*i +: 4] = 4'(m_dig[i]);
    return e;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_dig[i] = 0;
    m_cur = 0;
  endtask

  task automatic model_reset();
    m_clear();
    m_mode = 0; m_idle = 0; m_valid = 0; m_err = 0; m_to = 0;
    m_code = 0; m_centry = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] k, input logic [3:0] c, input logic r);
    int kc, kk;
    kc = -1; kk = -1;
    for (int i = 3; i >= 0; i--) begin
      if (c[i]) kc = i;
      if (k[i]) kk = i;
    end
    m_err = 0; m_to = 0;
    if (m_mode == 2) begin
      if (kc >= 0 || kk >= 0) m_err = 1;
      if (r) begin m_valid = 0; m_mode = 0; m_clear(); end
    end else if (kc >= 0) begin
      m_idle = 0;
      if (m_mode == 0) begin
        if (kc == 2) begin
          m_code = 2; m_centry = 0; m_valid = 1; m_mode = 2;
          exp_q.push_back({m_code, m_centry});
        end else if (kc < 2) m_err = 1;
      end else if (kc == 3) begin
        m_clear(); m_mode = 0;
      end else begin
        m_code = 2'(kc); m_centry = m_pack(); m_valid = 1; m_mode = 2;
        exp_q.push_back({m_code, m_centry});
      end
    end else if (kk >= 0) begin
      m_mode = 1; m_idle = 0;
      case (kk)
        0: m_dig[m_cur] = (m_dig[m_cur] + 1) % 10;
        1: m_dig[m_cur] = (m_dig[m_cur] + 9) % 10;
        2: m_cur = (m_cur + 1) % N;
        default: m_clear();
      endcase
    end else if (m_mode == 1) begin
      m_idle++;
      if (m_idle == TO - 1) begin m_clear(); m_mode = 0; m_to = 1; m_idle = 0; end
    end
  endtask

  task automatic compare_model();
    check("m_editing", 32'(EDITING), 32'(m_mode == 1));
    check("m_entry",   32'(ENTRY_BCD), 32'(m_pack()));
    check("m_cursor",  32'(CURSOR), 32'(m_cur));
    check("m_valid",   32'(CMD_VALID), 32'(m_valid));
    check("m_err",     32'(ERR), 32'(m_err));
    check("m_timeout", 32'(TIMEOUT), 32'(m_to));
    if (m_valid) begin
      check("m_code",   32'(CMD_CODE), 32'(m_code));
      check("m_centry", 32'(CMD_ENTRY), 32'(m_centry));
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs sampled likewise.
  task automatic cycle(input logic [3:0] k, input logic [3:0] c, input logic r);
    logic [W+1:0] exp;
    KEY_En = k; CMD_En = c; CMD_READY = r;
    if (CMD_VALID && r) begin
      check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check("sb_cmd", 32'({CMD_CODE, CMD_ENTRY}), 32'(exp));
      end
    end
    @(posedge CLOCK_50);
    model_step(k, c, r);
    #1;
    compare_model();
    KEY_En = 4'd0; CMD_En = 4'd0;
  endtask

  typedef struct {
    logic [3:0]   key, cmd;
    logic         ready, editing;
    logic [W-1:0] entry;
    logic [2:0]   cursor;
    logic         valid;
    logic [1:0]   code;
    logic [W-1:0] centry;
    logic         err;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] key, input logic [3:0] cmd, input logic ready,
                              input logic editing, input logic [W-1:0] entry, input logic [2:0] cursor,
                              input logic valid, input logic [1:0] code, input logic [W-1:0] centry,
                              input logic err);
    vec_t v;
    v.key = key; v.cmd = cmd; v.ready = ready; v.editing = editing; v.entry = entry;
    v.cursor = cursor; v.valid = valid; v.code = code; v.centry = centry; v.err = err;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    KEY_En = 4'd0; CMD_En = 4'd0; CMD_READY = 1'b0;
    model_reset();

    vecs.push_back(mk(4'h1, 4'h0, 0, 1, 12'h001, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 0, 1, 12'h002, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 0, 1, 12'h003, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 0, 1, 12'h003, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 0, 1, 12'h013, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h1, 0, 0, 12'h013, 1, 1, 0, 12'h013, 0));
    vecs.push_back(mk(4'h1, 4'h0, 0, 0, 12'h013, 1, 1, 0, 12'h013, 1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(4'h0, 4'h0, 0, 0, 12'h013, 1, 1, 0, 12'h013, 0));
    vecs.push_back(mk(4'h0, 4'h0, 1, 0, 12'h000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h2, 4'h0, 0, 1, 12'h009, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h0, 0, 1, 12'h000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 0, 1, 12'h000, 1, 0, 0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 0, 1, 12'h000, 2, 0, 0, 0, 0));
    vecs.push_back(mk(4'h4, 4'h0, 0, 1, 12'h000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h3, 4'h0, 0, 1, 12'h001, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 4'h8, 0, 0, 12'h000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h1, 0, 0, 12'h000, 0, 0, 0, 0, 1));
    vecs.push_back(mk(4'h0, 4'h0, 0, 0, 12'h000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h4, 0, 0, 12'h000, 0, 1, 2, 12'h000, 0));
    vecs.push_back(mk(4'h0, 4'h0, 1, 0, 12'h000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(4'h0, 4'h8, 0, 0, 12'h000, 0, 0, 0, 0, 0));

    // Reset values while RESET_N is held low.
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_valid",   32'(CMD_VALID), 0);
    check("reset_entry",   32'(ENTRY_BCD), 0);
    check("reset_centry",  32'(CMD_ENTRY), 0);
    check("reset_code",    32'(CMD_CODE), 0);
    check("reset_cursor",  32'(CURSOR), 0);
    check("reset_editing", 32'(EDITING), 0);
    check("reset_err",     32'(ERR), 0);
    check("reset_timeout", 32'(TIMEOUT), 0);
    RESET_N = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].key, vecs[i].cmd, vecs[i].ready);
      check($sformatf("vec%0d_editing", i), 32'(EDITING), 32'(vecs[i].editing));
      check($sformatf("vec%0d_entry", i),   32'(ENTRY_BCD), 32'(vecs[i].entry));
      check($sformatf("vec%0d_cursor", i),  32'(CURSOR), 32'(vecs[i].cursor));
      check($sformatf("vec%0d_valid", i),   32'(CMD_VALID), 32'(vecs[i].valid));
      check($sformatf("vec%0d_err", i),     32'(ERR), 32'(vecs[i].err));
      if (vecs[i].valid) begin
        check($sformatf("vec%0d_code", i),   32'(CMD_CODE), 32'(vecs[i].code));
        check($sformatf("vec%0d_centry", i), 32'(CMD_ENTRY), 32'(vecs[i].centry));
      end
    end

    // Inactivity: 15 quiet cycles after the last key discard the entry.
    cycle(4'h1, 4'h0, 0);
    for (int i = 1; i <= TO - 1; i++) begin
      cycle(4'h0, 4'h0, 0);
      check($sformatf("to_a_pulse%0d", i), 32'(TIMEOUT), 32'(i == TO - 1));
    end
    check("to_a_editing", 32'(EDITING), 0);
    check("to_a_entry",   32'(ENTRY_BCD), 0);
    cycle(4'h0, 4'h0, 0);
    check("to_a_pulse_end", 32'(TIMEOUT), 0);

    // A key at cycle 10 restarts the inactivity window.
    cycle(4'h1, 4'h0, 0);
    repeat (9) cycle(4'h0, 4'h0, 0);
    cycle(4'h1, 4'h0, 0);
    for (int i = 1; i <= TO - 1; i++) begin
      cycle(4'h0, 4'h0, 0);
      check($sformatf("to_b_pulse%0d", i), 32'(TIMEOUT), 32'(i == TO - 1));
      if (i < TO - 1) check($sformatf("to_b_entry%0d", i), 32'(ENTRY_BCD), 32'h002);
    end

    // Asynchronous reset in the middle of a pending command.
    cycle(4'h1, 4'h0, 0);
    cycle(4'h0, 4'h1, 0);
    check("ar_valid_before", 32'(CMD_VALID), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("ar_valid_async", 32'(CMD_VALID), 0);
    check("ar_entry_async", 32'(ENTRY_BCD), 0);
    model_reset();
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    cycle(4'h0, 4'h0, 1);
    check("ar_after_valid", 32'(CMD_VALID), 0);

    // Random pulses with occasional long quiet stretches.
    for (int n = 0; n < 800; n++) begin
      logic [3:0] k, c;
      logic       r;
      k = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      r = ($urandom_range(0, 2) == 0);
      cycle(k, c, r);
      if ($urandom_range(0, 59) == 0) repeat (TO) cycle(4'h0, 4'h0, 1'($urandom_range(0, 1)));
    end

    repeat (2) cycle(4'h0, 4'h0, 1);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
